// File: rtl/axis_pkg.sv
// Shared types and constants for the axis_seq_gen stream transmitter.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } gen_state_t;

  localparam int DEF_AXIS_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH       = 16;

  // Stall counter sticks at all-ones rather than wrapping back to zero
  localparam bit STALL_SATURATES = 1'b1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to throttle axis_seq_gen
// when AXIS_SEQ_GEN_THROTTLE_EN is defined.
module lfsr16
  import axis_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        rstn,
  input  logic        en,
  output logic [15:0] lfsr_state
);

  logic feedback_s;

  assign feedback_s = lfsr_state[15] ^ lfsr_state[13] ^ lfsr_state[12] ^ lfsr_state[10];

  // Shift register advance
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      lfsr_state <= SEED;
    end else if (en) begin
      lfsr_state <= {lfsr_state[14:0], feedback_s};
    end else begin
      lfsr_state <= lfsr_state;
    end
  end

endmodule

// File: rtl/axis_seq_gen.sv
// AXI-Stream burst generator: emits num_beats incrementing words from base_value.
// Optional random vld gaps between beats when AXIS_SEQ_GEN_THROTTLE_EN is defined.
module axis_seq_gen
  import axis_pkg::*;
#(
  parameter int          AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int          CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       aclk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       num_beats,
  input  logic [AXIS_DATA_WIDTH-1:0] base_value,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_data,
  output logic                       m_axis_vld,
  input  logic                       m_axis_rdy,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       beats_sent,
  output logic [CNT_WIDTH-1:0]       stall_cycles
);

  localparam logic [CNT_WIDTH-1:0]       CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]       CNT_ONES  = {CNT_WIDTH{1'b1}};
  localparam logic [AXIS_DATA_WIDTH-1:0] DATA_ZERO = {AXIS_DATA_WIDTH{1'b0}};
  localparam logic [AXIS_DATA_WIDTH-1:0] DATA_ONE  = {{(AXIS_DATA_WIDTH-1){1'b0}}, 1'b1};

  gen_state_t           state_r;
  logic [CNT_WIDTH-1:0] remaining_r;
  logic                 present_s;
  logic                 handshake_s;

`ifdef AXIS_SEQ_GEN_THROTTLE_EN
  logic [15:0] lfsr_s;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr16 (
    .aclk      (aclk),
    .rstn      (rstn),
    .en        (1'b1),
    .lfsr_state(lfsr_s)
  );

  // A new beat may only be offered on cycles where the LFSR permits it
  assign present_s = lfsr_s[0];
`else
  logic unused_seed_s;

  assign unused_seed_s = ^LFSR_SEED;
  assign present_s     = 1'b1;
`endif

  assign handshake_s = m_axis_vld && m_axis_rdy;

  // Burst FSM with all stream and status outputs registered
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      remaining_r  <= CNT_ZERO;
      m_axis_data  <= DATA_ZERO;
      m_axis_vld   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beats_sent   <= CNT_ZERO;
      stall_cycles <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            beats_sent   <= CNT_ZERO;
            stall_cycles <= CNT_ZERO;
            if (num_beats != CNT_ZERO) begin
              remaining_r <= num_beats;
              m_axis_data <= base_value;
              m_axis_vld  <= present_s;
              busy        <= 1'b1;
              state_r     <= SEND;
            end else begin
              done    <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        SEND: begin
          if (handshake_s) begin
            m_axis_data <= m_axis_data + DATA_ONE;
            remaining_r <= remaining_r - CNT_ONE;
            beats_sent  <= beats_sent + CNT_ONE;
            if (remaining_r == CNT_ONE) begin
              m_axis_vld <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state_r    <= FIN;
            end else begin
              m_axis_vld <= present_s;
            end
          end else if (m_axis_vld) begin
            // Beat already offered: hold data/vld until the sink accepts it
            if (STALL_SATURATES && (stall_cycles == CNT_ONES)) begin
              stall_cycles <= stall_cycles;
            end else begin
              stall_cycles <= stall_cycles + CNT_ONE;
            end
          end else begin
            m_axis_vld <= present_s;
          end
        end

        FIN: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          m_axis_vld <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_seq_gen.md
Name: axis_seq_gen

Overview:
- AXI-Stream transmitter. Drives the write side (data/vld/rdy) of the team's stream FIFO with a programmable burst of incrementing words.
- Used as the traffic source for FIFO bring-up and throughput measurement on a single clock domain.
- Reports busy/done status, a beat count and a backpressure stall count.

Parameters:
AXIS_DATA_WIDTH, 32, width of stream data word
CNT_WIDTH, 16, width of beat count and stall counters
LFSR_SEED, 16'hACE1, non-zero seed of throttle LFSR (used only with optional feature)

Ports:
aclk  input  1  clock; all logic on rising edge
rstn  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a burst; sampled only in IDLE
num_beats  input  CNT_WIDTH  burst length, sampled with start
base_value  input  AXIS_DATA_WIDTH  first data word, sampled with start
m_axis_data  output  AXIS_DATA_WIDTH  stream data
m_axis_vld  output  1  stream valid
m_axis_rdy  input  1  stream ready from sink
busy  output  1  high while a burst is in progress (SEND)
done  output  1  one-cycle pulse at burst completion
beats_sent  output  CNT_WIDTH  handshakes completed in current/last burst
stall_cycles  output  CNT_WIDTH  cycles with vld&&!rdy in current/last burst, saturating

Behaviour:
- Reset (async, rstn=0): state=IDLE, m_axis_vld=0, m_axis_data=0, busy=0, done=0, beats_sent=0, stall_cycles=0, LFSR=LFSR_SEED. Asserting reset mid-burst drops vld immediately; the partial burst is abandoned and not resumed.
- All outputs are registered; no combinational path from m_axis_rdy to any output.
- FSM states: IDLE, SEND, FIN.
- IDLE, start=1, num_beats!=0: latch num_beats into remaining, load data register with base_value, clear beats_sent/stall_cycles, go to SEND. vld=1 on the next cycle (start at cycle N gives vld at N+1).
- IDLE, start=1, num_beats=0: clear counters, go to FIN. vld is never asserted.
- SEND: handshake is vld&&rdy at a rising edge. On a handshake: data+1 (modulo 2^AXIS_DATA_WIDTH, wrap with no flag), remaining-1, beats_sent+1.
- SEND, handshake with remaining==1: vld<=0 and go to FIN. With rdy held high, beats go out on back-to-back cycles (one per cycle).
- SEND, vld=1 and rdy=0: data and vld hold stable; stall_cycles+1, saturating at all-ones.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. beats_sent and stall_cycles hold until the next accepted start.
- busy=1 exactly while state==SEND.
- start outside IDLE (SEND or FIN) is ignored and has no effect.
- Once asserted, vld never deasserts before a handshake (AXIS rule). Data must not change while vld=1 and rdy=0.

Optional Feature:
- Macro: AXIS_SEQ_GEN_THROTTLE_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. In SEND, a new beat is presented only when LFSR[0]=1; otherwise vld stays 0 for that cycle (a gap). The LFSR never gaps a beat already presented.
- When undefined: no LFSR logic; vld is continuous in SEND.
- beats_sent and data sequence are identical in both builds; only timing differs.

Decomposition:
- Shared package axis_pkg: state enum gen_state_t {IDLE, SEND, FIN}, default AXIS_DATA_WIDTH constant, stall saturation helper constant.
- One natural sub-module: lfsr16 (seed param, enable, state out), instantiated only under AXIS_SEQ_GEN_THROTTLE_EN.

Test Plan:
- rdy=1 always, base_value=0x10, num_beats=4, start at cycle 0 -> vld cycles 1-4 with data 0x10,0x11,0x12,0x13; done at cycle 5; beats_sent=4; stall_cycles=0.
- rdy=0 for 3 cycles while 0x11 is presented (num_beats=4) -> data held 0x11, vld held 1; stall_cycles=3; all 4 beats delivered in order.
- base_value=0xFFFFFFFE, num_beats=3 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; done pulses once.
- num_beats=0, start -> done pulse one cycle later; vld never 1; busy never 1; beats_sent=0.
- rstn low after 2 handshakes of an 8-beat burst -> vld/busy/beats_sent=0 without waiting for a clock edge; a new start with num_beats=2 afterwards delivers exactly 2 beats.
- start pulsed during SEND with different base_value -> ignored; original burst completes unchanged. With AXIS_SEQ_GEN_THROTTLE_EN: same data sequence and vld gaps present.
